// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle sequencer and the IF/DEC/ALU/MEM datapath.
// The master drives the stage strobes; the slave (datapath) supplies Instr and ALU_zero.
interface mc_control_fsm_if;
    logic [31:0] Instr;
    logic        ALU_zero;
    logic        PC_sel;
    logic        PC_LdEn;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        RF_B_sel;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        Mem_WrEn;
    logic        Halted;

    modport master (
        input  Instr, ALU_zero,
        output PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
               ALU_Bin_sel, ALU_func, Mem_WrEn, Halted
    );

    modport slave (
        output Instr, ALU_zero,
        input  PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
               ALU_Bin_sel, ALU_func, Mem_WrEn, Halted
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a data-memory wait-state
// counter. Outputs decode from the registered state and the opcode/func captured in FETCH.
module mc_control_fsm #(
    parameter int unsigned MEM_LAT    = 1,
    parameter bit          ILL_AS_NOP = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    mc_control_fsm_if.master  bus
);
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_RTYPE = 3'd0,
        CL_IMM   = 3'd1,
        CL_BEQ   = 3'd2,
        CL_BNE   = 3'd3,
        CL_B     = 3'd4,
        CL_LOAD  = 3'd5,
        CL_STORE = 3'd6,
        CL_ILL   = 3'd7
    } cls_t;

    localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 32'd1);

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'b100000:                                  return CL_RTYPE;
            6'b111000, 6'b111001, 6'b110000,
            6'b110010, 6'b110011:                       return CL_IMM;
            6'b000000:                                  return CL_BEQ;
            6'b000001:                                  return CL_BNE;
            6'b111111:                                  return CL_B;
            6'b000011, 6'b001111:                       return CL_LOAD;
            6'b000111, 6'b011111:                       return CL_STORE;
            default:                                    return CL_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_op(input cls_t cls, input logic [5:0] op,
                                          input logic [3:0] fn);
        case (cls)
            CL_RTYPE:       return fn;
            CL_IMM:         return (op == 6'b110010) ? 4'b0010 :
                                   (op == 6'b110011) ? 4'b0011 : 4'b0000;
            CL_BEQ, CL_BNE: return 4'b0001;
            default:        return 4'b0000;
        endcase
    endfunction

    state_t      state_r, state_s;
    logic [5:0]  opcode_r;
    logic [3:0]  func_r;
    logic [3:0]  count_r, count_s;
    cls_t        cls_s;
    logic [3:0]  alu_func_s;
    logic        bin_imm_s;
    logic        unused_instr_s;

    assign cls_s          = classify(opcode_r);
    assign alu_func_s     = alu_op(cls_s, opcode_r, func_r);
    assign bin_imm_s      = (cls_s == CL_IMM) || (cls_s == CL_LOAD) || (cls_s == CL_STORE);
    assign unused_instr_s = ^bus.Instr[25:4];

    // State, wait-state counter and captured opcode/func registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r  <= ST_FETCH;
            count_r  <= 4'd0;
            opcode_r <= 6'd0;
            func_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            if (state_r == ST_FETCH) begin
                opcode_r <= bus.Instr[31:26];
                func_r   <= bus.Instr[3:0];
            end
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_s           = state_r;
        count_s           = count_r;
        bus.PC_sel        = 1'b0;
        bus.PC_LdEn       = 1'b0;
        bus.RF_WrEn       = 1'b0;
        bus.RF_WrData_sel = 1'b0;
        bus.RF_B_sel      = 1'b0;
        bus.ALU_Bin_sel   = 1'b0;
        bus.ALU_func      = 4'b0000;
        bus.Mem_WrEn      = 1'b0;
        bus.Halted        = 1'b0;
        case (state_r)
            ST_FETCH: begin
                state_s = ST_DECODE;
            end
            ST_DECODE: begin
                bus.RF_B_sel = (cls_s == CL_BEQ) || (cls_s == CL_BNE) || (cls_s == CL_STORE);
                if (cls_s == CL_ILL) begin
                    if (ILL_AS_NOP) begin
                        bus.PC_LdEn = 1'b1;
                        state_s     = ST_FETCH;
                    end else begin
                        state_s = ST_HALT;
                    end
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.ALU_Bin_sel = bin_imm_s;
                bus.ALU_func    = alu_func_s;
                case (cls_s)
                    CL_BEQ: begin
                        bus.PC_LdEn = 1'b1;
                        bus.PC_sel  = bus.ALU_zero;
                        state_s     = ST_FETCH;
                    end
                    CL_BNE: begin
                        bus.PC_LdEn = 1'b1;
                        bus.PC_sel  = ~bus.ALU_zero;
                        state_s     = ST_FETCH;
                    end
                    CL_B: begin
                        bus.PC_LdEn = 1'b1;
                        bus.PC_sel  = 1'b1;
                        state_s     = ST_FETCH;
                    end
                    CL_LOAD, CL_STORE: begin
                        count_s = MEM_LAST;
                        state_s = ST_MEM;
                    end
                    default: begin
                        state_s = ST_WB;
                    end
                endcase
            end
            ST_MEM: begin
                // Address inputs held so the data RAM sees a stable address for every wait state.
                bus.ALU_Bin_sel = 1'b1;
                bus.ALU_func    = 4'b0000;
                if (count_r == 4'd0) begin
                    if (cls_s == CL_STORE) begin
                        bus.Mem_WrEn = 1'b1;
                        bus.PC_LdEn  = 1'b1;
                        state_s      = ST_FETCH;
                    end else begin
                        state_s = ST_WB;
                    end
                end else begin
                    count_s = count_r - 4'd1;
                end
            end
            ST_WB: begin
                bus.ALU_Bin_sel   = bin_imm_s;
                bus.ALU_func      = alu_func_s;
                bus.RF_WrEn       = 1'b1;
                bus.PC_LdEn       = 1'b1;
                bus.RF_WrData_sel = (cls_s == CL_LOAD);
                state_s           = ST_FETCH;
            end
            ST_HALT: begin
                bus.Halted = 1'b1;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench: two sequencer instances (MEM_LAT=3 / NOP-illegal, MEM_LAT=1 / halting)
// compared cycle by cycle against a per-instruction expected-output list.
module tb_mc_control_fsm;
    logic        Clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] instr_a = 32'd0, instr_b = 32'd0;
    logic        zero_a = 1'b0, zero_b = 1'b0;
    logic [11:0] obs_a, obs_b;
    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    mc_control_fsm_if ifa ();
    mc_control_fsm_if ifb ();

    assign ifa.Instr    = instr_a;
    assign ifa.ALU_zero = zero_a;
    assign ifb.Instr    = instr_b;
    assign ifb.ALU_zero = zero_b;
    assign obs_a = {ifa.Halted, ifa.Mem_WrEn, ifa.ALU_func, ifa.ALU_Bin_sel, ifa.RF_B_sel,
                    ifa.RF_WrData_sel, ifa.RF_WrEn, ifa.PC_LdEn, ifa.PC_sel};
    assign obs_b = {ifb.Halted, ifb.Mem_WrEn, ifb.ALU_func, ifb.ALU_Bin_sel, ifb.RF_B_sel,
                    ifb.RF_WrData_sel, ifb.RF_WrEn, ifb.PC_LdEn, ifb.PC_sel};

    mc_control_fsm #(.MEM_LAT(3), .ILL_AS_NOP(1'b1)) dut_a (.Clk(Clk), .Reset(rst_a), .bus(ifa));
    mc_control_fsm #(.MEM_LAT(1), .ILL_AS_NOP(1'b0)) dut_b (.Clk(Clk), .Reset(rst_b), .bus(ifb));

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    // Vector order: Halted, Mem_WrEn, ALU_func[3:0], ALU_Bin_sel, RF_B_sel,
    // RF_WrData_sel, RF_WrEn, PC_LdEn, PC_sel.
    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] ev(input bit hlt, input bit mem, input logic [3:0] fn,
                                       input bit bin, input bit rfb, input bit wds,
                                       input bit rfw, input bit pcl, input bit pcs);
        return {hlt, mem, fn, bin, rfb, wds, rfw, pcl, pcs};
    endfunction

    // Expected outputs for each cycle of one instruction, straight from the class rules.
    function automatic void build_exp(input int w, input logic [31:0] word, input logic z);
        logic [5:0] op;
        logic [3:0] f, af;
        bit is_r, is_imm, is_beq, is_bne, is_b, is_ld, is_st, legal, nop, bin;
        int lat;
        op     = word[31:26];
        f      = word[3:0];
        lat    = (w == 0) ? 3 : 1;
        nop    = (w == 0);
        is_r   = (op == 6'b100000);
        is_imm = op inside {6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011};
        is_beq = (op == 6'b000000);
        is_bne = (op == 6'b000001);
        is_b   = (op == 6'b111111);
        is_ld  = op inside {6'b000011, 6'b001111};
        is_st  = op inside {6'b000111, 6'b011111};
        legal  = is_r | is_imm | is_beq | is_bne | is_b | is_ld | is_st;
        af     = is_r ? f : (op == 6'b110010) ? 4'd2 : (op == 6'b110011) ? 4'd3 :
                 (is_beq | is_bne) ? 4'd1 : 4'd0;
        bin    = is_imm | is_ld | is_st;
        exp_q.delete();
        exp_q.push_back(12'h000);
        exp_q.push_back(ev(1'b0, 1'b0, 4'd0, 1'b0, is_beq | is_bne | is_st, 1'b0, 1'b0,
                           !legal && nop, 1'b0));
        if (!legal) begin
            if (!nop) repeat (4) exp_q.push_back(ev(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            return;
        end
        exp_q.push_back(ev(1'b0, 1'b0, af, bin, 1'b0, 1'b0, 1'b0, is_beq | is_bne | is_b,
                           is_beq ? z : is_bne ? !z : is_b));
        if (is_beq | is_bne | is_b) return;
        if (is_ld | is_st) begin
            for (int i = 0; i < lat; i++) begin
                exp_q.push_back(ev(1'b0, is_st && (i == lat - 1), 4'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                                   is_st && (i == lat - 1), 1'b0));
            end
            if (is_st) return;
        end
        exp_q.push_back(ev(1'b0, 1'b0, af, bin, 1'b0, is_ld, 1'b1, 1'b1, 1'b0));
    endfunction

    task automatic set_in(input int w, input logic [31:0] ins, input logic z);
        if (w == 0) begin
            instr_a = ins;
            zero_a  = z;
        end else begin
            instr_b = ins;
            zero_b  = z;
        end
    endtask

    task automatic set_rst(input int w, input logic v);
        if (w == 0) rst_a = v;
        else        rst_b = v;
    endtask

    // Runs one instruction starting mid-FETCH; abort_at >= 0 pulses reset after that cycle.
    task automatic run_instr(input int w, input logic [31:0] word, input logic z, input int abort_at);
        bit halt_end;
        build_exp(w, word, z);
        halt_end = exp_q[exp_q.size() - 1][11];
        for (int k = 0; k < exp_q.size(); k++) begin
            set_in(w, (k == 0) ? word : $urandom, (k == 2) ? z : 1'($urandom_range(0, 1)));
            #1;
            check_eq($sformatf("dut%0d op%02h c%0d", w, word[31:26], k + 1),
                     (w == 0) ? obs_a : obs_b, exp_q[k]);
            if (k == abort_at) break;
            @(negedge Clk);
        end
        if (abort_at >= 0 || halt_end) begin
            set_rst(w, 1'b0);
            #1;
            check_eq($sformatf("dut%0d reset_drop", w), (w == 0) ? obs_a : obs_b, 12'h000);
            @(negedge Clk);
            #1;
            check_eq($sformatf("dut%0d reset_hold", w), (w == 0) ? obs_a : obs_b, 12'h000);
            set_rst(w, 1'b1);
        end
    endtask

    function automatic logic [31:0] rand_word(input bit any_op);
        logic [5:0] legal_ops [14];
        logic [31:0] wd;
        legal_ops = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011,
                      6'b000000, 6'b000001, 6'b111111, 6'b000011, 6'b001111, 6'b000111,
                      6'b011111, 6'b101010};
        wd = $urandom;
        if (!any_op) wd[31:26] = legal_ops[$urandom_range(0, 13)];
        return wd;
    endfunction

    initial begin
        logic [31:0] wd;
        repeat (3) begin
            @(negedge Clk);
            #1;
            check_eq("dut0 in_reset", obs_a, 12'h000);
            check_eq("dut1 in_reset", obs_b, 12'h000);
        end
        @(negedge Clk);
        rst_a = 1'b1;
        // Directed cases on the MEM_LAT=3, illegal-as-NOP instance.
        run_instr(0, {6'b110000, 26'h0123456}, 1'b0, 3);
        run_instr(0, {6'b100000, 22'h2AAAAA, 4'b0000}, 1'b1, -1);
        run_instr(0, {6'b100000, 22'h155555, 4'b0110}, 1'b0, -1);
        run_instr(0, {6'b000000, 26'h0000010}, 1'b1, -1);
        run_instr(0, {6'b000000, 26'h0000010}, 1'b0, -1);
        run_instr(0, {6'b000001, 26'h0000020}, 1'b0, -1);
        run_instr(0, {6'b111111, 26'h3FFFFFF}, 1'b0, -1);
        run_instr(0, {6'b001111, 26'h0000004}, 1'b0, -1);
        run_instr(0, {6'b011111, 26'h0000008}, 1'b1, -1);
        run_instr(0, {6'b101010, 26'h0000000}, 1'b0, -1);
        run_instr(0, {6'b110010, 26'h000000F}, 1'b0, -1);
        run_instr(0, {6'b110011, 26'h0000000}, 1'b0, -1);
        for (int i = 0; i < 200; i++) begin
            wd = rand_word($urandom_range(0, 3) == 0);
            run_instr(0, wd, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1);
        end
        // MEM_LAT=1, halting instance.
        set_rst(1, 1'b1);
        run_instr(1, {6'b000011, 26'h0000100}, 1'b0, -1);
        run_instr(1, {6'b000111, 26'h0000200}, 1'b0, -1);
        run_instr(1, {6'b101010, 26'h0000000}, 1'b0, -1);
        run_instr(1, {6'b000001, 26'h0000000}, 1'b1, -1);
        run_instr(1, {6'b110000, 26'h0000007}, 1'b0, -1);
        for (int i = 0; i < 60; i++) begin
            wd = rand_word($urandom_range(0, 4) == 0);
            run_instr(1, wd, 1'($urandom_range(0, 1)), -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
